// File: rtl/nx_token_pkg.sv
// Shared types and constants for the outbound-channel token arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nx_token_pkg;

  // Arbiter control state: WAIT = no owner, HOLD = one node owns the channel.
  typedef enum logic {
    WAIT = 1'b0,
    HOLD = 1'b1
  } token_state_t;

  // Width of the wrapping grant counter when the instantiator does not override it.
  localparam int NX_TOKEN_DEFAULT_COUNT_WIDTH = 16;

endpackage : nx_token_pkg

// File: rtl/nx_rr_pick.sv
// Cyclic priority search: first set request bit at or after start_i, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on found_o.
module nx_rr_pick
  import nx_token_pkg::*;
#(
  parameter int NODES     = 4,
  parameter int IDX_WIDTH = $clog2(NODES)
) (
  input  logic [NODES-1:0]     req_i,
  input  logic [IDX_WIDTH-1:0] start_i,
  output logic                 found_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  int pos;

  // Scan offsets from farthest to nearest so the nearest request from start_i wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int off = NODES - 1; off >= 0; off--) begin
      pos = int'(start_i) + off;
      if (pos >= NODES) begin
        pos = pos - NODES;
      end
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IDX_WIDTH'(pos);
      end
    end
  end

endmodule : nx_rr_pick

// File: rtl/nx_token_arbiter.sv
// Round-robin token arbiter for a shared outbound message channel; optional idle-skip via NX_TOKEN_SKIP_IDLE_EN.
// Latency: grant one cycle after enable in WAIT; release seen in M gives next grant no earlier than M+2.
// Backpressure: the owner holds the token indefinitely until it pulses its release bit; never revoked.
module nx_token_arbiter
  import nx_token_pkg::*;
#(
  parameter int NODES       = 4,
  parameter int IDX_WIDTH   = $clog2(NODES),
  parameter int COUNT_WIDTH = NX_TOKEN_DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [NODES-1:0]       node_idle_i,
  input  logic [NODES-1:0]       token_release_i,
  output logic [NODES-1:0]       token_grant_o,
  output logic                   holding_o,
  output logic [IDX_WIDTH-1:0]   holder_o,
  output logic                   idle_o,
  output logic                   error_o,
  output logic [COUNT_WIDTH-1:0] grant_count_o
);

  token_state_t           state_q, state_d;
  logic [NODES-1:0]       grant_q, grant_d;
  logic                   holding_q, holding_d;
  logic [IDX_WIDTH-1:0]   holder_q, holder_d;
  logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic                   cand_found;
  logic [IDX_WIDTH-1:0]   cand_idx;
  logic [NODES-1:0]       holder_mask;
  logic [IDX_WIDTH-1:0]   ptr_next;

`ifdef NX_TOKEN_SKIP_IDLE_EN
  logic [NODES-1:0] busy_vec;

  assign busy_vec = ~node_idle_i;

  // Idle nodes are skipped; nothing is granted when every node is idle.
  nx_rr_pick #(
    .NODES     (NODES),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req_i   (busy_vec),
    .start_i (ptr_q),
    .found_o (cand_found),
    .idx_o   (cand_idx)
  );
`else
  // Strict rotation: every node gets the token in turn, busy or not.
  assign cand_found = 1'b1;
  assign cand_idx   = ptr_q;
`endif

  // Release bits that may legally be set: only the current holder's.
  always_comb begin
    holder_mask           = '0;
    holder_mask[holder_q] = 1'b1;
  end

  // Rotation pointer after the holder releases; wraps from the last node to 0.
  always_comb begin
    ptr_next = '0;
    if (holder_q != IDX_WIDTH'(NODES - 1)) begin
      ptr_next = holder_q + IDX_WIDTH'(1);
    end
  end

  // Next-state logic: grant in WAIT, wait for the holder's release in HOLD, flag stray releases.
  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    holding_d = holding_q;
    holder_d  = holder_q;
    ptr_d     = ptr_q;
    error_d   = error_q;
    count_d   = count_q;
    case (state_q)
      WAIT: begin
        // Nobody owns the token, so any release is a protocol violation.
        if (|token_release_i) begin
          error_d = 1'b1;
        end
        if (enable_i && cand_found) begin
          grant_d[cand_idx] = 1'b1;
          holder_d          = cand_idx;
          holding_d         = 1'b1;
          count_d           = count_q + COUNT_WIDTH'(1);
          state_d           = HOLD;
        end
      end
      HOLD: begin
        // Non-holder release bits are flagged but otherwise ignored.
        if (|(token_release_i & ~holder_mask)) begin
          error_d = 1'b1;
        end
        // enable_i is deliberately not consulted: the token is never revoked.
        if (token_release_i[holder_q]) begin
          holding_d = 1'b0;
          ptr_d     = ptr_next;
          state_d   = WAIT;
        end
      end
      default: begin
        state_d = WAIT;
      end
    endcase
  end

  // State and registered outputs; reset wins over everything, including a held token.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WAIT;
      grant_q   <= '0;
      holding_q <= 1'b0;
      holder_q  <= '0;
      ptr_q     <= '0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      holding_q <= holding_d;
      holder_q  <= holder_d;
      ptr_q     <= ptr_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  assign token_grant_o = grant_q;
  assign holding_o     = holding_q;
  assign holder_o      = holder_q;
  assign error_o       = error_q;
  assign grant_count_o = count_q;

  // Quiescent only when no owner, no grant in flight, and every node reports idle.
  assign idle_o = (state_q == WAIT) && !(|grant_q) && (&node_idle_i);

endmodule : nx_token_arbiter

// File: tb/tb_nx_token_arbiter.sv
// Directed self-checking bench for nx_token_arbiter.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: releases are driven by the bench acting as the node controllers.
module tb_nx_token_arbiter;

  localparam int NODES = 4;
  localparam int IDX_WIDTH = 2;
  localparam int COUNT_WIDTH = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   enable_i;
  logic [NODES-1:0]       node_idle_i;
  logic [NODES-1:0]       token_release_i;
  logic [NODES-1:0]       token_grant_o;
  logic                   holding_o;
  logic [IDX_WIDTH-1:0]   holder_o;
  logic                   idle_o;
  logic                   error_o;
  logic [COUNT_WIDTH-1:0] grant_count_o;

  int checks = 0;
  int failures = 0;

  nx_token_arbiter #(
    .NODES       (NODES),
    .IDX_WIDTH   (IDX_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .node_idle_i     (node_idle_i),
    .token_release_i (token_release_i),
    .token_grant_o   (token_grant_o),
    .holding_o       (holding_o),
    .holder_o        (holder_o),
    .idle_o          (idle_o),
    .error_o         (error_o),
    .grant_count_o   (grant_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; node_idle_i = 4'b1111; token_release_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    checks++; if (token_grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", token_grant_o); end
    checks++; if (holding_o !== 1'b0) begin failures++; $display("FAIL reset_holding got=%b want=0", holding_o); end
    checks++; if (holder_o !== 2'd0) begin failures++; $display("FAIL reset_holder got=%0d want=0", holder_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", error_o); end
    checks++; if (grant_count_o !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", grant_count_o); end
    checks++; if (idle_o !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", idle_o); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    node_idle_i = 4'b0000;
    enable_i = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      checks++; if (token_grant_o !== exp_g) begin failures++; $display("FAIL rot_grant k=%0d got=%b want=%b", k, token_grant_o, exp_g); end
      checks++; if (holder_o !== 2'(k % 4)) begin failures++; $display("FAIL rot_holder k=%0d got=%0d want=%0d", k, holder_o, k % 4); end
      checks++; if (grant_count_o !== 16'(k + 1)) begin failures++; $display("FAIL rot_count k=%0d got=%0d want=%0d", k, grant_count_o, k + 1); end
      tick();
      checks++; if (token_grant_o !== 4'b0000 || holding_o !== 1'b1) begin failures++; $display("FAIL rot_pulse k=%0d grant=%b holding=%b want 0000/1", k, token_grant_o, holding_o); end
      tick();
      token_release_i = exp_g;
      if (k == 4) enable_i = 1'b0;
      tick();
      token_release_i = '0;
      checks++; if (token_grant_o !== 4'b0000 || holding_o !== 1'b0) begin failures++; $display("FAIL rot_gap k=%0d grant=%b holding=%b want 0000/0", k, token_grant_o, holding_o); end
      if (k < 4) tick();
    end
    tick();
    checks++; if (grant_count_o !== 16'd5) begin failures++; $display("FAIL rot_total got=%0d want=5", grant_count_o); end
    checks++; if (token_grant_o !== 4'b0000 || idle_o !== 1'b0) begin failures++; $display("FAIL rot_disabled grant=%b idle=%b want 0000/0", token_grant_o, idle_o); end
  endtask

  task automatic test_long_hold();
    int bad;
    do_reset();
    node_idle_i = 4'b0000;
    enable_i = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick(); tick();
      token_release_i = 4'b0001 << k;
      tick();
      token_release_i = '0;
      tick();
    end
    checks++; if (token_grant_o !== 4'b1000 || holder_o !== 2'd3) begin failures++; $display("FAIL hold_grant3 grant=%b holder=%0d want 1000/3", token_grant_o, holder_o); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (token_grant_o !== 4'b0000 || holding_o !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_quiet bad_cycles=%0d want=0", bad); end
    token_release_i = 4'b1000;
    tick();
    token_release_i = '0;
    checks++; if (holding_o !== 1'b0 || token_grant_o !== 4'b0000) begin failures++; $display("FAIL hold_gap holding=%b grant=%b want 0/0000", holding_o, token_grant_o); end
    tick();
    checks++; if (token_grant_o !== 4'b0001 || holder_o !== 2'd0) begin failures++; $display("FAIL hold_wrap grant=%b holder=%0d want 0001/0", token_grant_o, holder_o); end
    checks++; if (grant_count_o !== 16'd5) begin failures++; $display("FAIL hold_count got=%0d want=5", grant_count_o); end
    enable_i = 1'b0;
  endtask

  task automatic test_enable_drop();
    int bad;
    do_reset();
    node_idle_i = 4'b0000;
    enable_i = 1'b1;
    tick();
    tick(); tick();
    token_release_i = 4'b0001;
    tick();
    token_release_i = '0;
    tick();
    checks++; if (token_grant_o !== 4'b0010) begin failures++; $display("FAIL drop_grant1 got=%b want=0010", token_grant_o); end
    enable_i = 1'b0;
    node_idle_i = 4'b1111;
    tick();
    checks++; if (idle_o !== 1'b0 || holding_o !== 1'b1) begin failures++; $display("FAIL drop_held idle=%b holding=%b want 0/1", idle_o, holding_o); end
    tick();
    token_release_i = 4'b0010;
    tick();
    token_release_i = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (token_grant_o !== 4'b0000) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL drop_nogrant bad_cycles=%0d want=0", bad); end
    checks++; if (holding_o !== 1'b0 || idle_o !== 1'b1) begin failures++; $display("FAIL drop_idle holding=%b idle=%b want 0/1", holding_o, idle_o); end
    node_idle_i = 4'b1101;
    #1;
    checks++; if (idle_o !== 1'b0) begin failures++; $display("FAIL drop_busy_idle got=%b want=0", idle_o); end
  endtask

  task automatic test_stray_release();
    do_reset();
    node_idle_i = 4'b0000;
    enable_i = 1'b0;
    token_release_i = 4'b0010;
    tick();
    token_release_i = '0;
    checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL stray_wait got=%b want=1", error_o); end
    do_reset();
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL stray_clear got=%b want=0", error_o); end
    enable_i = 1'b1;
    tick();
    tick();
    token_release_i = 4'b0100;
    tick();
    token_release_i = '0;
    checks++; if (error_o !== 1'b1 || holding_o !== 1'b1 || holder_o !== 2'd0) begin failures++; $display("FAIL stray_hold err=%b holding=%b holder=%0d want 1/1/0", error_o, holding_o, holder_o); end
    tick(); tick(); tick();
    checks++; if (error_o !== 1'b1 || holding_o !== 1'b1 || token_grant_o !== 4'b0000) begin failures++; $display("FAIL stray_sticky err=%b holding=%b grant=%b want 1/1/0000", error_o, holding_o, token_grant_o); end
    token_release_i = 4'b0101;
    enable_i = 1'b0;
    tick();
    token_release_i = '0;
    checks++; if (holding_o !== 1'b0 || error_o !== 1'b1) begin failures++; $display("FAIL stray_honoured holding=%b err=%b want 0/1", holding_o, error_o); end
  endtask

  task automatic test_candidate();
    do_reset();
    node_idle_i = 4'b1011;
    enable_i = 1'b1;
    tick();
`ifdef NX_TOKEN_SKIP_IDLE_EN
    checks++; if (token_grant_o !== 4'b0100 || holder_o !== 2'd2) begin failures++; $display("FAIL skip_grant2 grant=%b holder=%0d want 0100/2", token_grant_o, holder_o); end
    tick(); tick();
    token_release_i = 4'b0100;
    node_idle_i = 4'b1111;
    tick();
    token_release_i = '0;
    tick(); tick(); tick();
    checks++; if (token_grant_o !== 4'b0000 || holding_o !== 1'b0 || idle_o !== 1'b1) begin failures++; $display("FAIL skip_allidle grant=%b holding=%b idle=%b want 0000/0/1", token_grant_o, holding_o, idle_o); end
    node_idle_i = 4'b0110;
    tick();
    checks++; if (token_grant_o !== 4'b1000 || holder_o !== 2'd3) begin failures++; $display("FAIL skip_ptr3 grant=%b holder=%0d want 1000/3", token_grant_o, holder_o); end
`else
    checks++; if (token_grant_o !== 4'b0001 || holder_o !== 2'd0) begin failures++; $display("FAIL strict_grant0 grant=%b holder=%0d want 0001/0", token_grant_o, holder_o); end
    tick(); tick();
    token_release_i = 4'b0001;
    tick();
    token_release_i = '0;
    tick();
    checks++; if (token_grant_o !== 4'b0010 || holder_o !== 2'd1) begin failures++; $display("FAIL strict_grant1 grant=%b holder=%0d want 0010/1", token_grant_o, holder_o); end
`endif
    enable_i = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    node_idle_i = 4'b0000;
    enable_i = 1'b1;
    tick();
    tick(); tick();
    token_release_i = 4'b0011;
    tick();
    token_release_i = '0;
    tick();
    checks++; if (token_grant_o !== 4'b0010 || grant_count_o !== 16'd2 || error_o !== 1'b1) begin failures++; $display("FAIL mid_setup grant=%b count=%0d err=%b want 0010/2/1", token_grant_o, grant_count_o, error_o); end
    tick();
    rst_i = 1'b1;
    tick();
    checks++; if (token_grant_o !== 4'b0000 || holding_o !== 1'b0 || holder_o !== 2'd0) begin failures++; $display("FAIL mid_reset grant=%b holding=%b holder=%0d want 0000/0/0", token_grant_o, holding_o, holder_o); end
    checks++; if (error_o !== 1'b0 || grant_count_o !== 16'd0) begin failures++; $display("FAIL mid_reset_err_cnt err=%b count=%0d want 0/0", error_o, grant_count_o); end
    rst_i = 1'b0;
    tick();
    checks++; if (token_grant_o !== 4'b0001 || holder_o !== 2'd0 || grant_count_o !== 16'd1) begin failures++; $display("FAIL mid_regrant grant=%b holder=%0d count=%0d want 0001/0/1", token_grant_o, holder_o, grant_count_o); end
    enable_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_long_hold();
    test_enable_drop();
    test_stray_release();
    test_candidate();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nx_token_arbiter
